sram_lsu_master: RTL and testbench
==================================

Name: sram_lsu_master

Overview:
- Initiator side of the single-port SRAM interface (cs / wren / 4-bit byte mask / 1-cycle registered read).
- Accepts byte, half and word load/store requests from the pipeline MEM stage over a valid/ready handshake.
- Performs lane alignment and write-mask generation, and splits misaligned accesses that cross a word boundary into two SRAM beats.
- Returns sign- or zero-extended load data as a one-cycle response pulse.

Parameters:
- AW, 32: byte-address width of the request port.
- MEM_AW, 32: word-address width driven to the SRAM.
- DW, 32: data width; fixed at 32, 4 byte lanes.
- DEPTH, 100: number of SRAM words; word indices >= DEPTH are out of range.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  request valid
- o_req_ready  out  1  high only in IDLE
- i_req_addr  in  AW  byte address
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- i_req_unsigned  in  1  zero-extend load (LBU/LHU)
- i_req_wdata  in  DW  store data, right-justified
- o_rsp_valid  out  1  one-cycle completion pulse, loads and stores
- o_rsp_rdata  out  DW  extended load data; 0 for stores and errors
- o_rsp_err  out  1  out-of-range or illegal size
- o_mem_addr  out  MEM_AW  SRAM word index
- o_mem_wdata  out  DW  lane-aligned write data
- o_mem_cs  out  1  SRAM chip select
- o_mem_wren  out  1  SRAM write enable
- o_mem_bmask  out  4  SRAM byte mask
- i_mem_rdata  in  DW  SRAM read data, valid the cycle after a read beat

Behaviour:
- Reset: state IDLE.
  - o_req_ready = 1.
  - All other outputs 0: rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_cs, mem_wren, mem_bmask.
- Reset mid-operation: aborts immediately; mem_cs drops asynchronously; no response is issued.
- All SRAM-side and response outputs are registered.
- Accept: on i_req_valid & o_req_ready, latch the request and compute:
  - off = addr[1:0]
  - n = 1/2/4 from size
  - widx = addr >> 2
  - split = (off + n > 4)
- Error check at accept: size == 11, or widx + split >= DEPTH.
  - Go straight to DONE with err = 1 and rdata = 0.
  - mem_cs is never asserted.
- Lane math, using a 64-bit pair {word1, word0}:
  - wide_wdata = wdata << (8*off)
  - wide_mask = ((1 << n) - 1) << off (8 bits)
  - Beat0 uses the low halves at widx; beat1 uses the high halves at widx + 1.
- Load beats always drive bmask = 4'hF, because the SRAM only updates masked lanes of its output.
- FSM:
  - IDLE: ready = 1. On accept -> BEAT0 (or DONE on error).
  - BEAT0: cs = 1, wren = we, addr = widx, beat0 wdata/mask. Next: BEAT1 if split; else RDWAIT for a load; else DONE.
  - BEAT1: cs = 1, addr = widx + 1, beat1 wdata/mask. For a load, capture i_mem_rdata as word0. Next: RDWAIT for a load, else DONE.
  - RDWAIT: cs = 0. Capture i_mem_rdata as the last word (word0 if not split, else word1). Next: DONE.
  - DONE: rsp_valid = 1 for one cycle, with rdata and err. Next: IDLE.
- Load format:
  - r = {word1, word0} >> (8*off), truncated to n bytes.
  - Sign-extend from bit 8n-1 unless unsigned; word loads are passed through.
- Latency, accept cycle T to rsp_valid:
  - aligned store T+2
  - aligned load T+3
  - split store T+3
  - split load T+4
- No response backpressure: the requester must sink the rsp_valid pulse.
- No accept in BEAT0, BEAT1, RDWAIT or DONE; i_req_valid is ignored there.
- mem_cs is low in IDLE, RDWAIT and DONE.
- Back-to-back: the next request can be accepted in the IDLE cycle immediately after DONE.

Decomposition:
- Package sram_lsu_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_ILL)
  - state enum (IDLE, BEAT0, BEAT1, RDWAIT, DONE)
  - localparam NLANES = 4
- One combinational sub-module, sram_lane_align:
  - wide wdata/mask generation
  - load extraction and extension
  - split and error computation
- The top level holds the FSM and registers.

Test Plan:
1. Aligned SW then LW, addr 0x10, data 0xDEADBEEF, against the SRAM model -> beat with addr 4, bmask F, wren 1; rsp at T+2; the load returns 0xDEADBEEF at T+3 with err 0.
2. SB 0x80 to addr 0x13 over word 0x11223344 -> bmask 8, wdata 0x80000000; then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; word now reads 0x80223344.
3. Misaligned SW 0xAABBCCDD at addr 0x0E -> beat0 addr 3, bmask C, wdata 0xCCDD0000; beat1 addr 4, bmask 3, wdata 0x0000AABB; LW 0x0E returns 0xAABBCCDD at T+4.
4. LH at addr 0x18F (widx 99, split) with DEPTH = 100 -> cs never asserted; rsp_valid with err 1 and rdata 0 at T+1; size = 11 behaves the same way.
5. i_req_valid held high over 3 back-to-back loads -> ready only in IDLE; exactly 3 responses, in order, with no dropped or duplicated beats.
6. Assert i_reset during BEAT1 of a split store -> cs drops the same cycle; no rsp_valid; ready = 1 after release; the next request completes normally.

Source files
------------

// File: rtl/sram_lsu_pkg.sv
// Shared types for the SRAM load/store master: access sizes and FSM states.
package sram_lsu_pkg;

    localparam int unsigned NLANES = 4;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RDWAIT,
        DONE
    } state_e;

endpackage

// File: rtl/sram_lsu_master_align.sv
// Combinational lane math: write alignment/masks across a two-word window,
// split/range detection, and load extraction with sign/zero extension.
module sram_lane_align
    import sram_lsu_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned MEM_AW = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned DEPTH  = 100
) (
    input  logic [AW-1:0]     addr,
    input  size_e             size,
    input  logic              is_unsigned,
    input  logic [DW-1:0]     wdata,
    input  logic [DW-1:0]     word0,
    input  logic [DW-1:0]     word1,
    output logic [MEM_AW-1:0] widx,
    output logic              split,
    output logic              err,
    output logic [DW-1:0]     wdata0,
    output logic [DW-1:0]     wdata1,
    output logic [NLANES-1:0] mask0,
    output logic [NLANES-1:0] mask1,
    output logic [DW-1:0]     ldata
);

    localparam int unsigned IW  = AW + 1;
    localparam int unsigned WMW = 2 * NLANES;

    logic [1:0]      off;
    logic [2:0]      nbytes;
    logic [AW-1:0]   wfull;
    logic [IW-1:0]   last_idx;
    logic [2*DW-1:0] wide_w;
    logic [2*DW-1:0] rsh;
    logic [WMW-1:0]  wide_m;

    always_comb begin
        off = addr[1:0];
        case (size)
            SZ_B:    nbytes = 3'd1;
            SZ_H:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase

        wfull    = addr >> 2;
        widx     = MEM_AW'(wfull);
        split    = ({1'b0, off} + nbytes) > 3'd4;
        // The last word touched (second beat when split) must still be in range.
        last_idx = {1'b0, wfull} + IW'(split);
        err      = (size == SZ_ILL) || (last_idx >= IW'(DEPTH));

        wide_w = {{DW{1'b0}}, wdata} << {off, 3'b000};
        wide_m = ((WMW'(1) << nbytes) - WMW'(1)) << off;
        wdata0 = wide_w[DW-1:0];
        wdata1 = wide_w[2*DW-1:DW];
        mask0  = wide_m[NLANES-1:0];
        mask1  = wide_m[WMW-1:NLANES];

        rsh = {word1, word0} >> {off, 3'b000};
        case (size)
            SZ_B:    ldata = {{(DW-8){~is_unsigned & rsh[7]}}, rsh[7:0]};
            SZ_H:    ldata = {{(DW-16){~is_unsigned & rsh[15]}}, rsh[15:0]};
            default: ldata = rsh[DW-1:0];
        endcase
    end

endmodule

// File: rtl/sram_lsu_master.sv
// Single-port SRAM load/store initiator: request handshake, one or two SRAM
// beats per access, registered one-cycle response pulse.
module sram_lsu_master
    import sram_lsu_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned MEM_AW = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned DEPTH  = 100
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [AW-1:0]     i_req_addr,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [DW-1:0]     i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DW-1:0]     o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [DW-1:0]     o_mem_wdata,
    output logic              o_mem_cs,
    output logic              o_mem_wren,
    output logic [3:0]        o_mem_bmask,
    input  logic [DW-1:0]     i_mem_rdata
);

    state_e state, state_n;

    logic [AW-1:0] addr_q;
    logic          we_q, uns_q, split_q;
    size_e         size_q;
    logic [DW-1:0] wdata_q, word0_q, word0_n;
    logic          accept;

    logic [AW-1:0]     al_addr;
    size_e             al_size;
    logic              al_uns;
    logic [DW-1:0]     al_wdata, al_w0, al_w1;
    logic [MEM_AW-1:0] al_widx;
    logic              al_split, al_err;
    logic [DW-1:0]     al_wdata0, al_wdata1, al_ldata;
    logic [3:0]        al_mask0, al_mask1;

    logic              rsp_valid_n, rsp_err_n, cs_n, wren_n;
    logic [DW-1:0]     rsp_rdata_n, wdata_n;
    logic [MEM_AW-1:0] addr_n;
    logic [3:0]        bmask_n;

    assign o_req_ready = (state == IDLE);

    // In IDLE the aligner looks at the live request so beat0 can be
    // registered on the accept edge; afterwards it works from the latched copy.
    assign al_addr  = o_req_ready ? i_req_addr             : addr_q;
    assign al_size  = o_req_ready ? size_e'(i_req_size)    : size_q;
    assign al_uns   = o_req_ready ? i_req_unsigned         : uns_q;
    assign al_wdata = o_req_ready ? i_req_wdata            : wdata_q;
    assign al_w0    = split_q ? word0_q : i_mem_rdata;
    assign al_w1    = split_q ? i_mem_rdata : '0;

    sram_lane_align #(
        .AW     (AW),
        .MEM_AW (MEM_AW),
        .DW     (DW),
        .DEPTH  (DEPTH)
    ) u_align (
        .addr        (al_addr),
        .size        (al_size),
        .is_unsigned (al_uns),
        .wdata       (al_wdata),
        .word0       (al_w0),
        .word1       (al_w1),
        .widx        (al_widx),
        .split       (al_split),
        .err         (al_err),
        .wdata0      (al_wdata0),
        .wdata1      (al_wdata1),
        .mask0       (al_mask0),
        .mask1       (al_mask1),
        .ldata       (al_ldata)
    );

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        word0_n     = word0_q;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = '0;
        rsp_err_n   = 1'b0;
        cs_n        = 1'b0;
        wren_n      = 1'b0;
        addr_n      = '0;
        wdata_n     = '0;
        bmask_n     = '0;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    accept = 1'b1;
                    if (al_err) begin
                        state_n     = DONE;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else begin
                        state_n = BEAT0;
                        cs_n    = 1'b1;
                        wren_n  = i_req_we;
                        addr_n  = al_widx;
                        wdata_n = al_wdata0;
                        bmask_n = i_req_we ? al_mask0 : '1;
                    end
                end
            end
            BEAT0: begin
                if (split_q) begin
                    state_n = BEAT1;
                    cs_n    = 1'b1;
                    wren_n  = we_q;
                    addr_n  = al_widx + MEM_AW'(1);
                    wdata_n = al_wdata1;
                    bmask_n = we_q ? al_mask1 : '1;
                end else if (!we_q) begin
                    state_n = RDWAIT;
                end else begin
                    state_n     = DONE;
                    rsp_valid_n = 1'b1;
                end
            end
            BEAT1: begin
                if (!we_q) begin
                    word0_n = i_mem_rdata;
                    state_n = RDWAIT;
                end else begin
                    state_n     = DONE;
                    rsp_valid_n = 1'b1;
                end
            end
            RDWAIT: begin
                state_n     = DONE;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = al_ldata;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            size_q      <= SZ_B;
            wdata_q     <= '0;
            word0_q     <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_cs    <= 1'b0;
            o_mem_wren  <= 1'b0;
            o_mem_bmask <= '0;
        end else begin
            state       <= state_n;
            word0_q     <= word0_n;
            o_rsp_valid <= rsp_valid_n;
            o_rsp_rdata <= rsp_rdata_n;
            o_rsp_err   <= rsp_err_n;
            o_mem_addr  <= addr_n;
            o_mem_wdata <= wdata_n;
            o_mem_cs    <= cs_n;
            o_mem_wren  <= wren_n;
            o_mem_bmask <= bmask_n;
            if (accept) begin
                addr_q  <= i_req_addr;
                we_q    <= i_req_we;
                uns_q   <= i_req_unsigned;
                size_q  <= size_e'(i_req_size);
                wdata_q <= i_req_wdata;
                split_q <= al_split;
            end
        end
    end

endmodule

// File: tb/tb_sram_lsu_master.sv
// Scoreboard bench for sram_lsu_master: byte-level reference memory, SRAM
// model, per-beat and per-response checks including latency.
module tb_sram_lsu_master;

    localparam int unsigned DEPTH = 100;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_cs;
    logic        o_mem_wren;
    logic [3:0]  o_mem_bmask;
    logic [31:0] i_mem_rdata;

    always #5 clk = ~clk;

    sram_lsu_master #(
        .AW     (32),
        .MEM_AW (32),
        .DW     (32),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (i_req_addr),
        .i_req_we       (i_req_we),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_cs       (o_mem_cs),
        .o_mem_wren     (o_mem_wren),
        .o_mem_bmask    (o_mem_bmask),
        .i_mem_rdata    (i_mem_rdata)
    );

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] wd;
        logic        err;
        logic        split;
        int unsigned acc;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic        wren;
        logic [3:0]  mask;
        logic [31:0] data;
    } beat_t;

    req_t        rsp_q[$];
    beat_t       beat_q[$];
    logic [7:0]  ref_b [0:4*DEPTH-1];
    logic [31:0] sram_w [0:DEPTH-1];
    logic [31:0] sram_q;
    logic        mem_clr;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    assign i_mem_rdata = sram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        return (old & ~lanes(m)) | (nw & lanes(m));
    endfunction

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read that only refreshes masked output lanes.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) sram_w[i] <= '0;
            sram_q <= '0;
        end else if (o_mem_cs && o_mem_addr < DEPTH) begin
            if (o_mem_wren)
                sram_w[o_mem_addr[6:0]] <= merge(sram_w[o_mem_addr[6:0]], o_mem_wdata, o_mem_bmask);
            else
                sram_q <= merge(sram_q, sram_w[o_mem_addr[6:0]], o_mem_bmask);
        end
    end

    initial begin : monitor
        req_t        r;
        beat_t       b;
        logic [31:0] v;
        int unsigned n;
        forever begin
            @(negedge clk);
            if (mem_clr) begin
                for (int i = 0; i < 4 * DEPTH; i++) ref_b[i] = 8'h00;
            end
            if (i_reset) begin
                rsp_q.delete();
                beat_q.delete();
            end else begin
                if (o_mem_cs) begin
                    if (beat_q.size() == 0) begin
                        check("cs_unexpected", {31'd0, o_mem_cs}, 32'd0);
                    end else begin
                        b = beat_q.pop_front();
                        check("beat_addr", o_mem_addr, b.addr);
                        check("beat_wren", {31'd0, o_mem_wren}, {31'd0, b.wren});
                        check("beat_mask", {28'd0, o_mem_bmask}, {28'd0, b.mask});
                        if (b.wren) check("beat_wdata", o_mem_wdata & lanes(b.mask), b.data);
                    end
                end
                if (o_mem_cs || o_rsp_valid) check("ready_busy", {31'd0, o_req_ready}, 32'd0);
                if (o_rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", {31'd0, o_rsp_valid}, 32'd0);
                    end else begin
                        r = rsp_q.pop_front();
                        n = nbytes(r.sz);
                        v = '0;
                        if (!r.err && r.we) begin
                            for (int i = 0; i < n; i++) ref_b[r.a + i] = r.wd[8*i +: 8];
                        end else if (!r.err) begin
                            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[r.a + i];
                            if (n == 1 && !r.uns) v = {{24{v[7]}}, v[7:0]};
                            if (n == 2 && !r.uns) v = {{16{v[15]}}, v[15:0]};
                        end
                        check("rsp_err", {31'd0, o_rsp_err}, {31'd0, r.err});
                        check("rsp_rdata", o_rsp_rdata, v);
                        check("rsp_latency", cyc - r.acc,
                              r.err ? 1 : (r.we ? (r.split ? 3 : 2) : (r.split ? 4 : 3)));
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
        req_t        r;
        beat_t       b;
        int unsigned n, off, guard;
        logic [3:0]  m0, m1;
        logic [31:0] d0, d1;
        @(negedge clk);
        i_req_valid    = 1'b1;
        i_req_addr     = a;
        i_req_we       = we;
        i_req_size     = sz;
        i_req_unsigned = uns;
        i_req_wdata    = wd;
        guard = 0;
        while (!o_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!o_req_ready) begin
            check("accept_timeout", {31'd0, o_req_ready}, 32'd1);
            return;
        end
        n       = nbytes(sz);
        off     = int'(a[1:0]);
        r.a     = a;
        r.we    = we;
        r.sz    = sz;
        r.uns   = uns;
        r.wd    = wd;
        r.split = (off + n) > 4;
        r.err   = (sz == 2'b11) || (((a >> 2) + (r.split ? 1 : 0)) >= DEPTH);
        r.acc   = cyc;
        rsp_q.push_back(r);
        if (!r.err) begin
            m0 = '0; m1 = '0; d0 = '0; d1 = '0;
            for (int i = 0; i < n; i++) begin
                int unsigned p;
                p = off + i;
                if (p < 4) begin
                    m0[p] = 1'b1;
                    d0[8*p +: 8] = wd[8*i +: 8];
                end else begin
                    m1[p-4] = 1'b1;
                    d1[8*(p-4) +: 8] = wd[8*i +: 8];
                end
            end
            b.addr = a >> 2;
            b.wren = we;
            b.mask = we ? m0 : 4'hF;
            b.data = d0;
            beat_q.push_back(b);
            if (r.split) begin
                b.addr = (a >> 2) + 1;
                b.mask = we ? m1 : 4'hF;
                b.data = d1;
                beat_q.push_back(b);
            end
        end
        @(posedge clk);
    endtask

    task automatic drain();
        int unsigned guard;
        @(negedge clk);
        i_req_valid = 1'b0;
        guard = 0;
        while (rsp_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (rsp_q.size() != 0) check("drain_timeout", rsp_q.size(), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1;
        mem_clr = 1'b1;
        i_req_valid = 1'b0;
        i_req_addr = '0;
        i_req_we = 1'b0;
        i_req_size = 2'b00;
        i_req_unsigned = 1'b0;
        i_req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, o_req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_mem_wdata", o_mem_wdata, 32'd0);
        check("rst_mem_cs", {31'd0, o_mem_cs}, 32'd0);
        check("rst_mem_wren", {31'd0, o_mem_wren}, 32'd0);
        check("rst_mem_bmask", {28'd0, o_mem_bmask}, 32'd0);
        i_reset = 1'b0;
        mem_clr = 1'b0;

        send(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF); drain();
        send(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);        drain();

        send(32'h10, 1'b1, 2'b10, 1'b0, 32'h11223344); drain();
        send(32'h13, 1'b1, 2'b00, 1'b0, 32'h00000080); drain();
        send(32'h13, 1'b0, 2'b00, 1'b0, 32'h0);        drain();
        send(32'h13, 1'b0, 2'b00, 1'b1, 32'h0);        drain();
        send(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);        drain();
        send(32'h12, 1'b0, 2'b01, 1'b0, 32'h0);        drain();

        send(32'h0E, 1'b1, 2'b10, 1'b0, 32'hAABBCCDD); drain();
        send(32'h0E, 1'b0, 2'b10, 1'b0, 32'h0);        drain();
        send(32'h0F, 1'b0, 2'b01, 1'b0, 32'h0);        drain();
        send(32'h0D, 1'b0, 2'b01, 1'b1, 32'h0);        drain();

        send(32'h18F, 1'b0, 2'b01, 1'b0, 32'h0);       drain();
        send(32'h10,  1'b0, 2'b11, 1'b0, 32'h0);       drain();
        send(32'h190, 1'b1, 2'b10, 1'b0, 32'h12345678); drain();
        send(32'h18C, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D); drain();
        send(32'h18E, 1'b0, 2'b01, 1'b0, 32'h0);       drain();
        send(32'h18D, 1'b0, 2'b10, 1'b0, 32'h0);       drain();

        // Three loads with valid held high throughout.
        send(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);
        send(32'h0F, 1'b0, 2'b01, 1'b1, 32'h0);
        send(32'h13, 1'b0, 2'b00, 1'b0, 32'h0);
        drain();

        // Reset during the second beat of a split store.
        send(32'h10E, 1'b1, 2'b10, 1'b0, 32'h55667788);
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_cs_before", {31'd0, o_mem_cs}, 32'd1);
        i_req_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        check("rst_cs_drop", {31'd0, o_mem_cs}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        end
        i_reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
        end
        send(32'h20, 1'b1, 2'b10, 1'b0, 32'h0BADC0DE); drain();
        send(32'h20, 1'b0, 2'b10, 1'b0, 32'h0);        drain();

        for (int k = 0; k < 30; k++) begin
            send($urandom_range(0, 159), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 2) != 0) drain();
        end
        drain();

        check("beats_left", beat_q.size(), 32'd0);
        check("rsps_left", rsp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
